// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE   = 2'd0,
    MODE_BOUNCE  = 2'd1,
    MODE_BREATHE = 2'd2
  } mode_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic int unsigned dmax(input int unsigned bits);
    return (1 << bits) - 1;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter and lit comparator; duty==DMAX forces the output fully on.
module led_pwm
  import led_seq_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_25mhz,
  input  logic                rst_i,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                lit_o
);

  localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(dmax(PWM_BITS));

  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk_25mhz) begin
    if (rst_i) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_cnt + 1'b1;
  end

  assign lit_o = (pwm_cnt < duty_i) || (duty_i == DMAX);

endmodule

// File: rtl/led_pattern_seq.sv
// LED animation sequencer (CHASE / BOUNCE / BREATHE) with PWM brightness.
// Define LED_GAMMA_EN for a squared (gamma~2) duty in BREATHE, one extra clk of lag.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int unsigned N_LED    = 8,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned BRIGHT   = 255,
  parameter int unsigned STEP     = 16
) (
  input  logic             clk_25mhz,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             next_i,
  output logic [N_LED-1:0] led_o
);

  localparam int unsigned POS_W = $clog2(N_LED);
  localparam logic [PWM_BITS-1:0] DMAX     = PWM_BITS'(dmax(PWM_BITS));
  localparam logic [PWM_BITS-1:0] BRIGHT_D = PWM_BITS'(BRIGHT);
  localparam logic [PWM_BITS:0]   STEP_W   = (PWM_BITS + 1)'(STEP);
  localparam logic [PWM_BITS:0]   DMAX_W   = {1'b0, DMAX};
  localparam logic [POS_W-1:0]    POS_LAST = POS_W'(N_LED - 1);
  localparam logic [POS_W-1:0]    POS_PEN  = POS_W'(N_LED - 2);

  mode_t               mode, mode_n;
  logic [POS_W-1:0]    pos, pos_n;
  logic                dir, dir_n;
  logic [PWM_BITS-1:0] duty, duty_n;
  logic [PWM_BITS:0]   sum, diff;
  logic [PWM_BITS-1:0] breathe_d, active_d;
  logic [N_LED-1:0]    onehot;
  logic                lit;

  always_ff @(posedge clk_25mhz) begin
    if (rst_i) begin
      mode <= MODE_CHASE;
      pos  <= '0;
      dir  <= DIR_UP;
      duty <= '0;
    end else begin
      mode <= mode_n;
      pos  <= pos_n;
      dir  <= dir_n;
      duty <= duty_n;
    end
  end

  // A mode change takes priority over a coincident tick, which is dropped.
  always_comb begin
    mode_n = mode;
    pos_n  = pos;
    dir_n  = dir;
    duty_n = duty;
    sum    = {1'b0, duty} + STEP_W;
    diff   = {1'b0, duty} - STEP_W;
    if (next_i) begin
      case (mode)
        MODE_CHASE:  mode_n = MODE_BOUNCE;
        MODE_BOUNCE: mode_n = MODE_BREATHE;
        default:     mode_n = MODE_CHASE;
      endcase
      pos_n  = '0;
      dir_n  = DIR_UP;
      duty_n = '0;
    end else if (tick_i) begin
      case (mode)
        MODE_CHASE: pos_n = (pos == POS_LAST) ? '0 : pos + 1'b1;
        MODE_BOUNCE: begin
          if (dir == DIR_UP) begin
            if (pos == POS_LAST) begin
              dir_n = DIR_DN;
              pos_n = POS_PEN;
            end else begin
              pos_n = pos + 1'b1;
            end
          end else begin
            if (pos == '0) begin
              dir_n = DIR_UP;
              pos_n = POS_W'(1);
            end else begin
              pos_n = pos - 1'b1;
            end
          end
        end
        MODE_BREATHE: begin
          if (dir == DIR_UP) begin
            if (sum >= DMAX_W) begin
              duty_n = DMAX;
              dir_n  = DIR_DN;
            end else begin
              duty_n = sum[PWM_BITS-1:0];
            end
          end else begin
            // diff MSB is the borrow: an underflow or exact zero both land on 0.
            if (diff[PWM_BITS] || (diff == '0)) begin
              duty_n = '0;
              dir_n  = DIR_UP;
            end else begin
              duty_n = diff[PWM_BITS-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] sq;
  logic [PWM_BITS-1:0]   g;

  assign sq = {{PWM_BITS{1'b0}}, duty} * {{PWM_BITS{1'b0}}, duty};

  always_ff @(posedge clk_25mhz) begin
    if (rst_i)              g <= '0;
    else if (duty == DMAX)  g <= DMAX;
    else                    g <= PWM_BITS'(sq >> PWM_BITS);
  end

  assign breathe_d = g;
`else
  assign breathe_d = duty;
`endif

  assign active_d = (mode == MODE_BREATHE) ? breathe_d : BRIGHT_D;
  assign onehot   = {{(N_LED-1){1'b0}}, 1'b1} << pos;

  led_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_pwm (
    .clk_25mhz(clk_25mhz),
    .rst_i    (rst_i),
    .duty_i   (active_d),
    .lit_o    (lit)
  );

  always_ff @(posedge clk_25mhz) begin
    if (rst_i)                      led_o <= '0;
    else if (mode == MODE_BREATHE)  led_o <= {N_LED{lit}};
    else                            led_o <= onehot & {N_LED{lit}};
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench for led_pattern_seq: a cycle model pushes the expected led_o, popped one clk later.
module tb_led_pattern_seq;

  localparam int N  = 8;
  localparam int PB = 8;
  localparam int BR = 255;
  localparam int ST = 64;
  localparam int DM = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       nxt = 1'b0;
  logic [7:0] led;

  always #20 clk = ~clk;

  led_pattern_seq #(
    .N_LED   (N),
    .PWM_BITS(PB),
    .BRIGHT  (BR),
    .STEP    (ST)
  ) dut (
    .clk_25mhz(clk),
    .rst_i    (rst),
    .tick_i   (tick),
    .next_i   (nxt),
    .led_o    (led)
  );

  int m_mode, m_pos, m_dir, m_duty, m_pwm, m_g;
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: led_o=%h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_lit(input int d);
    return (m_pwm < d) || (d == DM);
  endfunction

  function automatic logic [7:0] model_led();
    int d;
    if (m_mode == 2) begin
`ifdef LED_GAMMA_EN
      d = m_g;
`else
      d = m_duty;
`endif
      return m_lit(d) ? 8'hFF : 8'h00;
    end
    return m_lit(BR) ? (8'h01 << m_pos) : 8'h00;
  endfunction

  task automatic model_step(input logic tk, input logic nx, input logic rs);
    if (rs) begin
      m_mode = 0; m_pos = 0; m_dir = 0; m_duty = 0; m_pwm = 0; m_g = 0;
      return;
    end
    m_g   = (m_duty == DM) ? DM : (m_duty * m_duty) / 256;
    m_pwm = (m_pwm + 1) % 256;
    if (nx) begin
      m_mode = (m_mode + 1) % 3;
      m_pos = 0; m_dir = 0; m_duty = 0;
    end else if (tk) begin
      if (m_mode == 0) begin
        m_pos = (m_pos + 1) % N;
      end else if (m_mode == 1) begin
        if (m_dir == 0) begin
          if (m_pos == N - 1) begin m_dir = 1; m_pos = N - 2; end
          else m_pos = m_pos + 1;
        end else begin
          if (m_pos == 0) begin m_dir = 0; m_pos = 1; end
          else m_pos = m_pos - 1;
        end
      end else begin
        if (m_dir == 0) begin
          m_duty = m_duty + ST;
          if (m_duty >= DM) begin m_duty = DM; m_dir = 1; end
        end else begin
          m_duty = m_duty - ST;
          if (m_duty <= 0) begin m_duty = 0; m_dir = 0; end
        end
      end
    end
  endtask

  task automatic step(input logic tk, input logic nx, input logic rs, input string tag);
    @(negedge clk);
    tick = tk; nxt = nx; rst = rs;
    exp_q.push_back(rs ? 8'h00 : model_led());
    model_step(tk, nx, rs);
    @(posedge clk);
    #1;
    check_eq(tag, led, exp_q.pop_front());
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(i[0], ~i[0], 1'b1, "reset");
    idle(3, "post_reset");

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, "chase_tick");
      idle(3, "chase_hold");
    end

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, "chase_to3");
      idle(2, "chase_to3_hold");
    end
    step(1'b1, 1'b1, 1'b0, "simul_tick_next");
    idle(3, "simul_hold");
    step(1'b1, 1'b0, 1'b0, "simul_first_tick");
    idle(3, "simul_after");

    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 1'b0, "bounce_tick");
      idle(4, "bounce_hold");
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "bounce_held_tick");
    idle(3, "bounce_held_after");

    step(1'b0, 1'b1, 1'b0, "to_breathe");
    idle(259, "breathe_zero");
    for (int i = 0; i < 13; i++) begin
      step(1'b1, 1'b0, 1'b0, "breathe_tick");
      idle(259, "breathe_level");
    end

    step(1'b0, 1'b0, 1'b1, "reset_mid_breathe");
    idle(5, "after_mid_reset");

    step(1'b1, 1'b1, 1'b1, "reset_with_next");
    idle(5, "chase_after_reset");
    step(1'b1, 1'b0, 1'b0, "chase_first_tick");
    idle(5, "chase_final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
